// File: rtl/globals_cu_pkg.sv
// rtl/globals_cu_pkg.sv - struct-type tag codes shared across the compute-unit filter paths
package globals_cu_pkg;

  localparam logic [31:0] STRUCT_INVALID            = 32'hFFFF_FFFF;
  localparam logic [31:0] VERTEX_VALUE_HOT_U32      = 32'h0000_0011;
  localparam logic [31:0] VERTEX_CACHE_WARM_U32     = 32'h0000_0012;
  localparam logic [31:0] VERTEX_VALUE_LUKEWARM_U32 = 32'h0000_0013;
  localparam logic [31:0] VERTEX_VALUE_COLD_U32     = 32'h0000_0014;

  // Lane index -> tag carried on sel_out for beats sourced from that lane.
  localparam logic [31:0] LANE_SEL_TAG [4] = '{
    VERTEX_VALUE_COLD_U32,
    VERTEX_CACHE_WARM_U32,
    VERTEX_VALUE_LUKEWARM_U32,
    VERTEX_VALUE_HOT_U32
  };

endpackage

// File: rtl/blk_d8e1b4_if.sv
// rtl/blk_d8e1b4_if.sv - four-lane input / single merged output bus of the criterion mux
interface blk_d8e1b4_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 4,
  parameter int SEL_WIDTH  = 32
);

  logic [BUS_WIDTH-1:0][DATA_WIDTH-1:0] data_in;
  logic [BUS_WIDTH-1:0]                 data_in_valid;
  logic [BUS_WIDTH-1:0]                 data_in_ready;
  logic [DATA_WIDTH-1:0]                data_out;
  logic [SEL_WIDTH-1:0]                 sel_out;
  logic                                 data_out_valid;
  logic                                 data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, sel_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, sel_out, data_out_valid
  );

endinterface

// File: rtl/vertex_criterion_lane_fifo.sv
// rtl/vertex_criterion_lane_fifo.sv - per-lane synchronous FIFO with head-of-queue read
module vertex_criterion_lane_fifo #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 4,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];

  // Full is judged on the pre-pop count, so a full FIFO refuses a push even while draining.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers wrap naturally; count tracks push minus pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer/count registers; reset empties the FIFO.
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care while the slot is not counted.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/blk_d8e1b4.sv
// rtl/blk_d8e1b4.sv - round-robin merge of four vertex-criterion lanes into one tagged stream
module blk_d8e1b4 #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 4,
  parameter int SEL_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clock,
  input  logic         rst,
  blk_d8e1b4_if.slave  bus
);

  import globals_cu_pkg::*;

  localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] fifo_head [BUS_WIDTH];
  logic [CNT_W-1:0]      fifo_count [BUS_WIDTH];
  logic [BUS_WIDTH-1:0]  fifo_empty;
  logic [BUS_WIDTH-1:0]  fifo_full;
  logic [BUS_WIDTH-1:0]  lane_ready;
  logic [BUS_WIDTH-1:0]  lane_push;
  logic [BUS_WIDTH-1:0]  lane_pop;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  valid_q, valid_d;
  logic [1:0]            last_grant_q, last_grant_d;

  logic                  load_en;
  logic                  grant_found;
  logic [1:0]            grant_lane;
  logic [1:0]            cand;

  // Output register may take a new beat when empty or when the current one is being taken.
  assign load_en = !valid_q || bus.data_out_ready;

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_lane
    // Ready is held low through reset and otherwise reflects the pre-pop occupancy.
    assign lane_ready[i] = !rst && (fifo_count[i] != FULL_COUNT);
    assign lane_push[i]  = bus.data_in_valid[i] && !rst && !fifo_full[i];
    assign lane_pop[i]   = load_en && grant_found && (grant_lane == 2'(i));

    vertex_criterion_lane_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clock       (clock),
      .rst         (rst),
      .push_i      (lane_push[i]),
      .pop_i       (lane_pop[i]),
      .push_data_i (bus.data_in[i]),
      .head_data_o (fifo_head[i]),
      .count_o     (fifo_count[i]),
      .empty_o     (fifo_empty[i]),
      .full_o      (fifo_full[i])
    );
  end

  assign bus.data_in_ready  = lane_ready;
  assign bus.data_out       = data_q;
  assign bus.sel_out        = sel_q;
  assign bus.data_out_valid = valid_q;

  // Round-robin scan: first non-empty lane after the last grant, wrapping through all four.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = last_grant_q;
    cand        = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_found && !fifo_empty[cand]) begin
        grant_found = 1'b1;
        grant_lane  = cand;
      end
    end
  end

  // Output stage next state; with no candidate only valid drops, data/tag/pointer hold.
  always_comb begin
    data_d       = data_q;
    sel_d        = sel_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (grant_found) begin
        data_d       = fifo_head[grant_lane];
        sel_d        = SEL_WIDTH'(LANE_SEL_TAG[grant_lane]);
        valid_d      = 1'b1;
        last_grant_d = grant_lane;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Output register and arbitration pointer; reset makes lane0 first in line.
  always_ff @(posedge clock) begin
    if (rst) begin
      data_q       <= '0;
      sel_q        <= SEL_WIDTH'(STRUCT_INVALID);
      valid_q      <= 1'b0;
      last_grant_q <= 2'd3;
    end else begin
      data_q       <= data_d;
      sel_q        <= sel_d;
      valid_q      <= valid_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
